// File: rtl/des_key_pkg.sv
// Shared constants, permutation helpers and FSM encoding for the iterative DES key schedule.
// Bit order everywhere: the MSB of a vector carries DES bit 1.
package des_key_pkg;

    localparam int ROUNDS = 16;
    localparam int KEY_W  = 64;
    localparam int SK_W   = 48;
    localparam int CD_W   = 28;
    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [6:0] PC1_TAB [0:55] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [5:0] PC2_TAB [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Shift amount of round idx+1: returns 1 for a two-position rotate, 0 for one position.
    function automatic logic shift_two(input logic [3:0] idx);
        logic two;
        case (idx)
            4'd0, 4'd1, 4'd8, 4'd15: two = 1'b0;
            default:                 two = 1'b1;
        endcase
        return two;
    endfunction

    function automatic logic [55:0] pc1(input logic [KEY_W-1:0] k);
        logic [55:0] cd;
        cd = '0;
        for (int j = 0; j < 56; j++) begin
            cd[6'(55 - j)] = k[6'(7'd64 - PC1_TAB[6'(j)])];
        end
        return cd;
    endfunction

    function automatic logic [SK_W-1:0] pc2(input logic [55:0] cd);
        logic [SK_W-1:0] sk;
        sk = '0;
        for (int j = 0; j < SK_W; j++) begin
            sk[6'(47 - j)] = cd[6'd56 - PC2_TAB[6'(j)]];
        end
        return sk;
    endfunction

endpackage

// File: rtl/des_cd_rotate.sv
// Combinational 28+28-bit circular rotator for the C and D halves (1 or 2 positions, either way).
module des_cd_rotate
    import des_key_pkg::*;
(
    input  logic [CD_W-1:0] c,
    input  logic [CD_W-1:0] d,
    input  logic            two,
    input  logic            right,
    output logic [CD_W-1:0] c_rot,
    output logic [CD_W-1:0] d_rot
);

    // Left moves the MSB (DES bit 1) around to the LSB; right is the inverse.
    function automatic logic [CD_W-1:0] rot28(input logic [CD_W-1:0] v, input logic amt2,
                                              input logic dir_right);
        logic [CD_W-1:0] r;
        case ({dir_right, amt2})
            2'b00:   r = {v[26:0], v[27]};
            2'b01:   r = {v[25:0], v[27:26]};
            2'b10:   r = {v[0], v[27:1]};
            2'b11:   r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign c_rot = rot28(c, two, right);
    assign d_rot = rot28(d, two, right);

endmodule

// File: rtl/des_key_sequencer.sv
// Iterative DES key-schedule controller: one C/D register pair and one shared rotator
// hand out K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready handshake.
module des_key_sequencer
    import des_key_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            select,
    input  logic [KEY_W-1:0] key,
    input  logic            abort,
    output logic            sk_valid,
    input  logic            sk_ready,
    output logic [SK_W-1:0] sk_data,
    output logic [3:0]      sk_round,
    output logic            busy,
    output logic            done
);

    state_t          state_r, state_s;
    logic            mode_r, mode_s;
    logic [3:0]      count_r, count_s;
    logic [CD_W-1:0] c_r, c_s, d_r, d_s;
    logic            valid_r, busy_r, done_r;
    logic [55:0]     key_cd_s;
    logic [3:0]      next_idx_s;
    logic [CD_W-1:0] rot_c_s, rot_d_s, c_rot_s, d_rot_s;
    logic            rot_two_s, rot_right_s;

    assign key_cd_s = pc1(key);

    // Decrypt walks the table backwards, so its next shift comes from the far end.
    assign next_idx_s = mode_r ? (LAST_IDX - count_r) : (count_r + 4'd1);

    // Rotator source: the fresh PC1 image while idle, the live C/D pair otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            rot_c_s     = key_cd_s[55:28];
            rot_d_s     = key_cd_s[27:0];
            rot_two_s   = 1'b0;
            rot_right_s = 1'b0;
        end else begin
            rot_c_s     = c_r;
            rot_d_s     = d_r;
            rot_two_s   = shift_two(next_idx_s);
            rot_right_s = mode_r;
        end
    end

    des_cd_rotate u_rotate (
        .c     (rot_c_s),
        .d     (rot_d_s),
        .two   (rot_two_s),
        .right (rot_right_s),
        .c_rot (c_rot_s),
        .d_rot (d_rot_s)
    );

    // Next-state and datapath update; abort overrides start and any handshake.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        count_s = count_r;
        c_s     = c_r;
        d_s     = d_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_RUN;
                        mode_s  = select;
                        count_s = 4'd0;
                        // Decrypt starts from C16/D16, which equals C0/D0 after 28 total shifts.
                        if (select) begin
                            c_s = key_cd_s[55:28];
                            d_s = key_cd_s[27:0];
                        end else begin
                            c_s = c_rot_s;
                            d_s = d_rot_s;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (sk_ready) begin
                        if (count_r == LAST_IDX) begin
                            state_s = ST_DONE;
                        end else begin
                            count_s = count_r + 4'd1;
                            c_s     = c_rot_s;
                            d_s     = d_rot_s;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DONE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, key-schedule registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= 1'b0;
            count_r <= 4'd0;
            c_r     <= '0;
            d_r     <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            count_r <= count_s;
            c_r     <= c_s;
            d_r     <= d_s;
            valid_r <= (state_s == ST_RUN);
            busy_r  <= (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign sk_valid = valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sk_data  = valid_r ? pc2({c_r, d_r}) : '0;
    assign sk_round = valid_r ? (mode_r ? (LAST_IDX - count_r) : count_r) : 4'd0;

endmodule

// File: tb/tb_des_key_sequencer.sv
// Randomized self-checking bench: a from-scratch DES key-schedule model predicts every output cycle.
`timescale 1ns/1ps
module tb_des_key_sequencer;

    localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;

    logic        clk = 1'b0;
    logic        rst_n, start, select, abort, sk_ready;
    logic [63:0] key;
    logic        sk_valid, busy, done;
    logic [47:0] sk_data;
    logic [3:0]  sk_round;

    always #5 clk = ~clk;

    des_key_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .select(select), .key(key), .abort(abort),
        .sk_valid(sk_valid), .sk_ready(sk_ready), .sk_data(sk_data), .sk_round(sk_round),
        .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                       60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                       29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int sh_t [16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // Subkey Kn straight from the textbook definition: total left shift of C0/D0, then PC2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int n);
        bit cd0 [1:56];
        bit cdn [1:56];
        int t;
        logic [47:0] r;
        t = 0;
        for (int i = 1; i <= n; i++) t += sh_t[i-1];
        for (int j = 1; j <= 56; j++) cd0[j] = k[64 - pc1_t[j-1]];
        for (int j = 1; j <= 28; j++) begin
            cdn[j]      = cd0[((j - 1 + t) % 28) + 1];
            cdn[j + 28] = cd0[((j - 1 + t) % 28) + 29];
        end
        for (int j = 1; j <= 48; j++) r[48 - j] = cdn[pc2_t[j-1]];
        return r;
    endfunction

    // Transaction-level model: active run, handshakes completed, done pulse.
    logic        m_active, m_done, m_mode;
    int          m_idx;
    logic [63:0] m_key;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_done <= 1'b0; m_mode <= 1'b0; m_idx <= 0; m_key <= '0;
        end else begin
            m_done <= 1'b0;
            if (abort) begin
                m_active <= 1'b0;
            end else if (!m_active && !m_done) begin
                if (start) begin
                    m_active <= 1'b1; m_idx <= 0; m_mode <= select; m_key <= key;
                end
            end else if (m_active && sk_ready) begin
                if (m_idx == 15) begin
                    m_active <= 1'b0; m_done <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    // Per-cycle compare against the model, plus hold-while-stalled check.
    logic        chk_en = 1'b0;
    logic        last_valid = 1'b0;
    logic [47:0] last_data = '0;
    logic [3:0]  last_round = '0;
    always @(negedge clk) begin
        int kn;
        if (rst_n && chk_en) begin
            check("valid", sk_valid, m_active);
            check("busy", busy, m_active);
            check("done", done, m_done);
            if (m_active) begin
                kn = m_mode ? 16 - m_idx : m_idx + 1;
                check("data", sk_data, ref_subkey(m_key, kn));
                check("round", sk_round, kn - 1);
            end
            if (last_valid && !sk_ready && !abort) begin
                check("stall_valid", sk_valid, 1'b1);
                check("stall_data", sk_data, last_data);
                check("stall_round", sk_round, last_round);
            end
            last_valid = sk_valid;
            last_data  = sk_data;
            last_round = sk_round;
        end else begin
            last_valid = 1'b0;
        end
    end

    logic [47:0] got_data [16];
    logic [3:0]  got_round [16];
    logic [47:0] enc_seq [16];
    int got_n, got_done, done_at;

    task automatic run_sched(input logic [63:0] k, input logic sel, input int ready_pct,
                             input int abort_at, input bit noise);
        bit finished, just_aborted;
        int post;
        finished = 1'b0; just_aborted = 1'b0; post = 0;
        got_n = 0; got_done = 0; done_at = -1;
        start = 1'b1; key = k; select = sel; abort = 1'b0; sk_ready = 1'b1;
        for (int it = 1; it <= 300; it++) begin
            @(negedge clk); #1;
            if (just_aborted) begin
                check("abort_drop_valid", sk_valid, 1'b0);
                just_aborted = 1'b0;
            end
            if (done) begin
                got_done++;
                if (done_at < 0) done_at = it;
                finished = 1'b1;
            end
            if (finished) post++;
            abort  = 1'b0;
            key    = {$urandom, $urandom};
            select = 1'($urandom);
            start  = noise && !finished ? 1'($urandom) : 1'b0;
            sk_ready = ($urandom_range(99) < ready_pct);
            if (!finished && abort_at >= 0 && sk_valid && got_n == abort_at) begin
                abort = 1'b1; sk_ready = 1'b1; finished = 1'b1; just_aborted = 1'b1;
            end else if (sk_valid && sk_ready && got_n < 16) begin
                got_data[got_n]  = sk_data;
                got_round[got_n] = sk_round;
                got_n++;
            end
            if (post >= 3) break;
        end
        start = 1'b0; abort = 1'b0;
        check("sched_finished", finished, 1'b1);
    endtask

    initial begin
        logic [63:0] rk;
        rst_n = 1'b0; start = 1'b0; select = 1'b0; key = '0; abort = 1'b0; sk_ready = 1'b0;

        check("model_k1", ref_subkey(KEY0, 1), 48'h1B02EFFC7072);
        check("model_k2", ref_subkey(KEY0, 2), 48'h79AED9DBC9E5);
        check("model_k16", ref_subkey(KEY0, 16), 48'hCB3D8B0E17F5);

        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", sk_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_data", sk_data, 48'h0);
        check("rst_round", sk_round, 4'd0);
        rst_n = 1'b1; chk_en = 1'b1;
        @(negedge clk); #1;

        // Encrypt, no backpressure
        run_sched(KEY0, 1'b0, 100, -1, 1'b0);
        check("enc_count", got_n, 16);
        check("enc_dones", got_done, 1);
        check("enc_done_cycle", done_at, 17);
        check("enc_first", got_data[0], 48'h1B02EFFC7072);
        check("enc_first_round", got_round[0], 4'd0);
        check("enc_second", got_data[1], 48'h79AED9DBC9E5);
        check("enc_last", got_data[15], 48'hCB3D8B0E17F5);
        check("enc_last_round", got_round[15], 4'd15);
        for (int i = 0; i < 16; i++) enc_seq[i] = got_data[i];

        // Decrypt: exact reverse
        run_sched(KEY0, 1'b1, 100, -1, 1'b0);
        check("dec_count", got_n, 16);
        check("dec_first", got_data[0], 48'hCB3D8B0E17F5);
        check("dec_first_round", got_round[0], 4'd15);
        check("dec_last", got_data[15], 48'h1B02EFFC7072);
        check("dec_last_round", got_round[15], 4'd0);
        for (int i = 0; i < 16; i++) check("dec_reverse", got_data[i], enc_seq[15 - i]);

        // Random backpressure
        run_sched(KEY0, 1'b0, 50, -1, 1'b0);
        check("bp_count", got_n, 16);
        check("bp_dones", got_done, 1);
        for (int i = 0; i < 16; i++) check("bp_seq", got_data[i], enc_seq[i]);

        // Abort while step 7 is offered
        run_sched(KEY0, 1'b0, 100, 6, 1'b0);
        check("abort_count", got_n, 6);
        check("abort_dones", got_done, 0);
        run_sched(KEY0, 1'b0, 100, -1, 1'b0);
        check("post_abort_first", got_data[0], 48'h1B02EFFC7072);

        // Start/key/select noise while busy
        run_sched(KEY0, 1'b0, 70, -1, 1'b1);
        check("noise_count", got_n, 16);
        check("noise_dones", got_done, 1);
        for (int i = 0; i < 16; i++) check("noise_seq", got_data[i], enc_seq[i]);

        // Async reset mid-run
        start = 1'b1; key = KEY0; select = 1'b0; sk_ready = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", sk_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", sk_data, 48'h0);
        check("midrst_round", sk_round, 4'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        run_sched(KEY0, 1'b0, 100, -1, 1'b0);
        check("after_rst_count", got_n, 16);
        for (int i = 0; i < 16; i++) check("after_rst_seq", got_data[i], enc_seq[i]);

        // Random keys, modes and backpressure; model checks the data
        for (int r = 0; r < 6; r++) begin
            rk = {$urandom, $urandom};
            run_sched(rk, 1'($urandom), 30 + $urandom_range(70), -1, 1'($urandom));
            check("rand_count", got_n, 16);
            check("rand_dones", got_done, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
